btn_keycode_enc: RTL and testbench

Transmit-side counterpart of the keyboard keycode decoder in the 2048 game.
- Turns seven board pushbuttons into the same 8-bit USB-HID keycode stream a keyboard delivers: W/A/S/D, R, Enter, M.
- Each press becomes one keystroke: keycode held for HOLD_CYCLES, then 0x00 for GAP_CYCLES.
- The downstream decoder sees an exact keyboard press/release sequence.
- Sits between board buttons and the keycode input of the game's input decoder, muxed with the USB keyboard path.

---
 rtl/kb_pkg.sv | 45 ++++
 rtl/btn_keycode_enc_if.sv | 18 +
 rtl/btn_debounce.sv | 56 +++++
 rtl/btn_keycode_enc.sv | 134 +++++++++++++
 tb/tb_btn_keycode_enc.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/kb_pkg.sv
// Shared definitions for the pushbutton-to-keycode encoder.
// Holds the HID keycodes the game decoder understands, the button index
// order, the keystroke sequencer states and a priority helper.
package kb_pkg;

  localparam int NBTN = 7;

  localparam logic [7:0] KC_W     = 8'h1A;
  localparam logic [7:0] KC_A     = 8'h04;
  localparam logic [7:0] KC_S     = 8'h16;
  localparam logic [7:0] KC_D     = 8'h07;
  localparam logic [7:0] KC_R     = 8'h15;
  localparam logic [7:0] KC_ENTER = 8'h28;
  localparam logic [7:0] KC_M     = 8'h10;

  typedef enum logic [2:0] {
    BTN_UP    = 3'd0,
    BTN_LEFT  = 3'd1,
    BTN_DOWN  = 3'd2,
    BTN_RIGHT = 3'd3,
    BTN_RESET = 3'd4,
    BTN_START = 3'd5,
    BTN_MENU  = 3'd6
  } btn_idx_e;

  // Indexed by btn_idx_e.
  localparam logic [7:0] KC_MAP [NBTN] = '{KC_W, KC_A, KC_S, KC_D, KC_R, KC_ENTER, KC_M};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } kb_state_e;

  // Index of the lowest set bit; 0 when nothing is set (callers check first).
  function automatic logic [2:0] lowest_idx(input logic [NBTN-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NBTN - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/btn_keycode_enc_if.sv
// Button / keycode bundle between the board buttons, the encoder and the
// game's input decoder.
//   btn_raw    : raw active-high buttons (driven by the board side)
//   keycode    : HID keycode, 0x00 = no key
//   key_active : high while keycode is non-zero
//   pending    : presses registered but not yet sent
//   overflow   : one-cycle pulse when a press is dropped
// master = encoder, slave = board/decoder side.
interface btn_keycode_enc_if;
  logic [kb_pkg::NBTN-1:0] btn_raw;
  logic [7:0]              keycode;
  logic                    key_active;
  logic [kb_pkg::NBTN-1:0] pending;
  logic                    overflow;

  modport master (input btn_raw, output keycode, key_active, pending, overflow);
  modport slave  (output btn_raw, input keycode, key_active, pending, overflow);
endinterface

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, debounce counter and a press pulse.
//   clk, rst_n : clock, async active-low reset
//   raw        : asynchronous button input
//   press      : one-cycle pulse in the first cycle the debounced level is 1
// A new level is accepted after DEB_CYCLES consecutive synchronized samples
// that differ from the current stable level; any bounce restarts the count.
module btn_debounce #(
  parameter int DEB_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync_p0, sync_p1;
  logic          stable;
  logic [CW-1:0] cnt;

  // synchronizer stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // debounce stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_p1 != stable) begin
        if (cnt == CNT_LAST) begin
          cnt    <= '0;
          stable <= sync_p1;
          press  <= sync_p1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/btn_keycode_enc.sv
// Turns seven board pushbuttons into a USB-HID style keycode stream.
// Each debounced press becomes one keystroke: the keycode for HOLD_CYCLES,
// then 0x00 for GAP_CYCLES. Presses queue in a one-deep-per-button pending
// register and are sent lowest index first.
//   clk   : system clock
//   rst_n : async active-low reset (released synchronously inside)
//   bus   : btn_raw in; keycode, key_active, pending, overflow out
module btn_keycode_enc
  import kb_pkg::*;
#(
  parameter int DEB_CYCLES  = 1000,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4
) (
  input logic               clk,
  input logic               rst_n,
  btn_keycode_enc_if.master bus
);

  localparam int PH_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0] HOLD_LAST = PH_W'(HOLD_CYCLES - 1);
  localparam logic [PH_W-1:0] GAP_LAST  = PH_W'(GAP_CYCLES - 1);

  logic            rst_meta, rst_sync_n;
  logic [NBTN-1:0] press_vec;
  logic [NBTN-1:0] pending_q, grant;
  logic            overflow_q;
  kb_state_e       state, state_d;
  logic [PH_W-1:0] ph_cnt, ph_cnt_d;
  logic [7:0]      keycode_q, keycode_d;
  logic            key_active_q;
  logic [2:0]      gidx;

  // Reset asserts immediately, deasserts two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  genvar gb;
  generate
    for (gb = 0; gb < NBTN; gb++) begin : g_deb
      btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk   (clk),
        .rst_n (rst_sync_n),
        .raw   (bus.btn_raw[gb]),
        .press (press_vec[gb])
      );
    end
  endgenerate

  // State register plus the registered outputs.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state        <= IDLE;
      ph_cnt       <= '0;
      pending_q    <= '0;
      overflow_q   <= 1'b0;
      keycode_q    <= 8'h00;
      key_active_q <= 1'b0;
    end else begin
      state        <= state_d;
      ph_cnt       <= ph_cnt_d;
      // A press landing on a bit granted this cycle re-arms it, so set wins.
      pending_q    <= (pending_q & ~grant) | press_vec;
      overflow_q   <= |(press_vec & pending_q & ~grant);
      keycode_q    <= keycode_d;
      key_active_q <= (keycode_d != 8'h00);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state;
    ph_cnt_d = ph_cnt;
    unique case (state)
      IDLE: begin
        if (|pending_q) begin
          state_d  = HOLD;
          ph_cnt_d = '0;
        end
      end
      HOLD: begin
        if (ph_cnt == HOLD_LAST) begin
          state_d  = GAP;
          ph_cnt_d = '0;
        end else begin
          ph_cnt_d = ph_cnt + 1'b1;
        end
      end
      GAP: begin
        if (ph_cnt == GAP_LAST) begin
          state_d  = IDLE;
          ph_cnt_d = '0;
        end else begin
          ph_cnt_d = ph_cnt + 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        ph_cnt_d = '0;
      end
    endcase
  end

  // Output logic: grant and the keycode to register for the next cycle.
  always_comb begin
    grant     = '0;
    keycode_d = 8'h00;
    gidx      = lowest_idx(pending_q);
    unique case (state)
      IDLE: begin
        if (|pending_q) begin
          grant     = NBTN'(1) << gidx;
          keycode_d = KC_MAP[gidx];
        end
      end
      HOLD:    keycode_d = (ph_cnt == HOLD_LAST) ? 8'h00 : keycode_q;
      default: keycode_d = 8'h00;
    endcase
  end

  assign bus.keycode    = keycode_q;
  assign bus.key_active = key_active_q;
  assign bus.pending    = pending_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_btn_keycode_enc.sv
module tb_btn_keycode_enc;

  localparam int DEB  = 4;
  localparam int HOLD = 3;
  localparam int GAP  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  btn_keycode_enc_if bus_if ();

  btn_keycode_enc #(
    .DEB_CYCLES  (DEB),
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Keycode table written out independently of the design package.
  logic [7:0] codes [7] = '{8'h1A, 8'h04, 8'h16, 8'h07, 8'h15, 8'h28, 8'h10};

  // Reference model: raw sample history, debounced levels, pending set and a
  // keystroke timeline (m_busy counts cycles until the sender is free again).
  logic [6:0] rawq [$];
  logic [6:0] hist [$];
  logic [6:0] m_stable, m_press, m_pend;
  logic       m_ovf;
  int         m_busy;
  int         m_rst_hold;
  logic [7:0] m_key, m_kc;

  int         starts [7];
  int         ovf_seen;
  logic [7:0] prev_kc;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    rawq.delete();
    rawq.push_back(7'h00);
    rawq.push_back(7'h00);
    hist.delete();
    m_stable = '0;
    m_press  = '0;
    m_pend   = '0;
    m_ovf    = 1'b0;
    m_busy   = 0;
    m_key    = 8'h00;
    m_kc     = 8'h00;
  endtask

  task automatic model_edge();
    logic [6:0] g;
    int         gi;
    logic [6:0] s;
    if (!rst_n || m_rst_hold > 0) begin
      if (!rst_n) m_rst_hold = 2;
      else        m_rst_hold--;
      model_clear();
      return;
    end
    g  = '0;
    gi = -1;
    if (m_busy == 0 && m_pend != 0)
      for (int i = 6; i >= 0; i--) if (m_pend[i]) gi = i;
    if (gi >= 0) g[gi] = 1'b1;
    m_ovf  = |(m_press & m_pend & ~g);
    m_pend = (m_pend & ~g) | m_press;
    if (gi >= 0) begin
      m_key  = codes[gi];
      m_busy = HOLD + GAP;
    end else if (m_busy > 0) begin
      m_busy--;
    end
    m_kc = (m_busy > GAP) ? m_key : 8'h00;
    // A button's level flips once its last DEB synchronized samples all differ.
    rawq.push_back(bus_if.btn_raw);
    if (rawq.size() > 3) void'(rawq.pop_front());
    s = rawq[rawq.size() - 3];
    hist.push_back(s);
    if (hist.size() > DEB) void'(hist.pop_front());
    m_press = '0;
    for (int i = 0; i < 7; i++) begin
      bit all_diff;
      all_diff = (hist.size() == DEB);
      foreach (hist[k]) if (hist[k][i] == m_stable[i]) all_diff = 1'b0;
      if (all_diff) begin
        m_stable[i] = ~m_stable[i];
        if (m_stable[i]) m_press[i] = 1'b1;
      end
    end
  endtask

  task automatic tick(input logic [6:0] raw);
    bus_if.btn_raw = raw;
    @(posedge clk);
    model_edge();
    #1;
    check("keycode", bus_if.keycode, m_kc);
    check("key_active", {7'b0, bus_if.key_active}, {7'b0, (m_kc != 8'h00)});
    check("pending", {1'b0, bus_if.pending}, {1'b0, m_pend});
    check("overflow", {7'b0, bus_if.overflow}, {7'b0, m_ovf});
    if (bus_if.keycode != 8'h00 && prev_kc == 8'h00)
      for (int i = 0; i < 7; i++) if (bus_if.keycode == codes[i]) starts[i]++;
    if (bus_if.overflow === 1'b1) ovf_seen++;
    prev_kc = bus_if.keycode;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 7; i++) starts[i] = 0;
    ovf_seen = 0;
  endtask

  initial begin
    logic [6:0] r;
    bit seen;
    bus_if.btn_raw = '0;
    prev_kc    = 8'h00;
    m_rst_hold = 2;
    model_clear();
    clear_counts();

    // Reset held, then released and left idle.
    for (int k = 0; k < 3; k++) tick(7'h00);
    rst_n = 1'b1;
    for (int k = 0; k < 50; k++) tick(7'h00);

    // Single long press on W.
    clear_counts();
    for (int k = 0; k < 20; k++) tick(7'h01);
    for (int k = 0; k < 20; k++) tick(7'h00);
    check("w_keystrokes", 8'(starts[0]), 8'd1);

    // Bouncing A, then a clean press.
    clear_counts();
    for (int k = 0; k < 12; k++) tick(((k / 2) % 2 == 0) ? 7'h02 : 7'h00);
    for (int k = 0; k < 10; k++) tick(7'h00);
    check("a_bounce_none", 8'(starts[1]), 8'd0);
    for (int k = 0; k < 10; k++) tick(7'h02);
    for (int k = 0; k < 20; k++) tick(7'h00);
    check("a_keystrokes", 8'(starts[1]), 8'd1);

    // D and Enter together: D first, then Enter.
    clear_counts();
    for (int k = 0; k < 10; k++) tick(7'h28);
    for (int k = 0; k < 20; k++) tick(7'h00);
    check("d_keystrokes", 8'(starts[3]), 8'd1);
    check("enter_keystrokes", 8'(starts[5]), 8'd1);

    // R pressed twice while lower-index keystrokes keep the sender busy.
    clear_counts();
    for (int k = 0; k < 7; k++) tick(7'h1F);
    for (int k = 0; k < 7; k++) tick(7'h00);
    for (int k = 0; k < 7; k++) tick(7'h10);
    for (int k = 0; k < 40; k++) tick(7'h00);
    check("r_overflow_pulses", 8'(ovf_seen), 8'd1);
    check("r_keystrokes", 8'(starts[4]), 8'd1);
    check("s_keystrokes", 8'(starts[2]), 8'd1);

    // M pressed so that its press lands during the GAP of a W keystroke.
    clear_counts();
    for (int k = 0; k < 5; k++) tick(7'h01);
    for (int k = 0; k < 5; k++) tick(7'h41);
    for (int k = 0; k < 5; k++) tick(7'h40);
    for (int k = 0; k < 25; k++) tick(7'h00);
    check("m_keystrokes", 8'(starts[6]), 8'd1);

    // Reset in the middle of a HOLD.
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      tick(7'h04);
      if (bus_if.keycode != 8'h00) seen = 1'b1;
    end
    check("midhold_started", {7'b0, seen}, 8'd1);
    rst_n = 1'b0;
    #1;
    check("rst_keycode", bus_if.keycode, 8'h00);
    check("rst_key_active", {7'b0, bus_if.key_active}, 8'h00);
    check("rst_pending", {1'b0, bus_if.pending}, 8'h00);
    for (int k = 0; k < 3; k++) tick(7'h00);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) tick(7'h00);

    // Random button activity, mixing bounces and real presses.
    r = '0;
    for (int k = 0; k < 900; k++) begin
      for (int i = 0; i < 7; i++)
        if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
      tick(r);
    end
    for (int k = 0; k < 60; k++) tick(7'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
